multicycle_ctrl: RTL and testbench

- Multicycle control FSM for the 5-bit-opcode CPU.
- Sequences fetch, decode, execute, memory and writeback over a shared single-port memory, ALU and register file.
- Replaces the single-cycle main decoder when the datapath runs multicycle; memory is accessed through a req/ready handshake.
- Detects illegal opcodes and memory timeouts and halts in a trap state.

---
 rtl/multicycle_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 5-bit-opcode CPU.
// Sequences fetch/decode/execute/mem/writeback, traps on illegal ops and bus timeouts.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] op,
  input  logic       zero,
  input  logic       memready,
  output logic       memreq,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       link,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       illegal,
  output logic       buserr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXE  = 4'd6,
    ALUWB  = 4'd7,
    IMMEXE = 4'd8,
    IMMWB  = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  typedef struct packed {
    logic       memreq;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       link;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       illegal;
    logic       buserr;
  } ctl_t;

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t        cur, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic          ill_q, ill_n;
  logic          bus_q, bus_n;
  ctl_t          c;

  logic is_r, is_imm, is_mem, is_br, is_jmp, is_jal;
  logic waiting, tmo;

  assign is_r   = (op[4:3] == 2'b01) || (op[4:3] == 2'b10);
  assign is_imm = (op[4:1] == 4'b1100);
  assign is_mem = (op[4:1] == 4'b1101);
  assign is_br  = (op[4:1] == 4'b1110);
  assign is_jal = (op == 5'b00111);
  assign is_jmp = (op == 5'b00000) || is_jal;

  assign waiting = ((cur == FETCH) || (cur == MEMRD) || (cur == MEMWR))
                   && !memready;
  assign tmo = (MEM_TIMEOUT != 0) && waiting
               && (cnt == CW'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      cur   <= FETCH;
      cnt   <= '0;
      ill_q <= 1'b0;
      bus_q <= 1'b0;
    end else begin
      cur   <= nxt;
      cnt   <= cnt_n;
      ill_q <= ill_n;
      bus_q <= bus_n;
    end
  end

  always_comb begin
    nxt   = cur;
    c     = '0;
    ill_n = ill_q;
    bus_n = bus_q;
    unique case (cur)
      FETCH: begin
        c.memreq  = 1'b1;
        c.alusrcb = 2'b01;
        c.irwrite = memready;
        c.pcen    = memready;
        if (memready) nxt = DECODE;
        else if (tmo) begin
          nxt   = TRAP;
          bus_n = 1'b1;
        end
      end
      DECODE: begin
        c.alusrcb = 2'b11;
        unique case (1'b1)
          is_r:    nxt = RTEXE;
          is_imm:  nxt = IMMEXE;
          is_mem:  nxt = MEMADR;
          is_br:   nxt = BRANCH;
          is_jmp:  nxt = JUMP;
          default: begin
            nxt   = TRAP;
            ill_n = 1'b1;
          end
        endcase
      end
      RTEXE: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
        nxt       = ALUWB;
      end
      ALUWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
        nxt        = FETCH;
      end
      IMMEXE: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluop   = op[0] ? 2'b11 : 2'b00;
        nxt       = IMMWB;
      end
      IMMWB: begin
        c.regwrite = 1'b1;
        nxt        = FETCH;
      end
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        nxt       = op[0] ? MEMWR : MEMRD;
      end
      MEMRD: begin
        c.memreq = 1'b1;
        c.iord   = 1'b1;
        if (memready) nxt = MEMWB;
        else if (tmo) begin
          nxt   = TRAP;
          bus_n = 1'b1;
        end
      end
      MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
        nxt        = FETCH;
      end
      MEMWR: begin
        c.memreq   = 1'b1;
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
        if (memready) nxt = FETCH;
        else if (tmo) begin
          nxt   = TRAP;
          bus_n = 1'b1;
        end
      end
      BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b11;
        c.pcsrc   = 2'b01;
        c.pcen    = op[0] ? ~zero : zero;
        nxt       = FETCH;
      end
      JUMP: begin
        c.pcsrc    = 2'b10;
        c.pcen     = 1'b1;
        c.regwrite = is_jal;
        c.link     = is_jal;
        nxt        = FETCH;
      end
      TRAP: begin
        c.illegal = ill_q;
        c.buserr  = bus_q;
      end
      default: nxt = FETCH;
    endcase
  end

  // Counter only runs while stalled in the same wait state.
  always_comb begin
    cnt_n = '0;
    if (waiting && (nxt == cur) && (MEM_TIMEOUT != 0))
      cnt_n = cnt + 1'b1;
  end

  assign {memreq, memwrite, iord, irwrite, pcen, regwrite, regdst,
          memtoreg, link, alusrca, alusrcb, aluop, pcsrc,
          illegal, buserr} = reset ? '0 : c;

  assign state = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl.
// Per-cycle expectations go through a queue and are checked at the falling edge.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset, zero, memready;
  logic [4:0] op;
  logic       memreq, memwrite, iord, irwrite, pcen, regwrite, regdst;
  logic       memtoreg, link, alusrca, illegal, buserr;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [3:0] state;
  logic [17:0] outs;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] o;
  } exp_t;

  exp_t q[$];

  // memreq memwrite iord irwrite pcen regwrite regdst memtoreg link alusrca
  // alusrcb aluop pcsrc illegal buserr
  localparam logic [17:0] F_W = 18'b1_0_0_0_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] F_R = 18'b1_0_0_1_1_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] DEC = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] RTE = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] AWB = 18'b0_0_0_0_0_1_1_0_0_0_00_00_00_0_0;
  localparam logic [17:0] IMA = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] IMS = 18'b0_0_0_0_0_0_0_0_0_1_10_11_00_0_0;
  localparam logic [17:0] IWB = 18'b0_0_0_0_0_1_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] MRD = 18'b1_0_1_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] MWB = 18'b0_0_0_0_0_1_0_1_0_0_00_00_00_0_0;
  localparam logic [17:0] MWR = 18'b1_1_1_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] BRT = 18'b0_0_0_0_1_0_0_0_0_1_00_11_01_0_0;
  localparam logic [17:0] BRN = 18'b0_0_0_0_0_0_0_0_0_1_00_11_01_0_0;
  localparam logic [17:0] JMP = 18'b0_0_0_0_1_0_0_0_0_0_00_00_10_0_0;
  localparam logic [17:0] JAL = 18'b0_0_0_0_1_1_0_0_1_0_00_00_10_0_0;
  localparam logic [17:0] TIL = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] TBE = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;
  localparam logic [17:0] ZZ  = 18'b0;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .memready(memready), .memreq(memreq), .memwrite(memwrite),
    .iord(iord), .irwrite(irwrite), .pcen(pcen), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .link(link),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsrc(pcsrc), .illegal(illegal), .buserr(buserr), .state(state)
  );

  assign outs = {memreq, memwrite, iord, irwrite, pcen, regwrite, regdst,
                 memtoreg, link, alusrca, alusrcb, aluop, pcsrc,
                 illegal, buserr};

  always #5 clk = ~clk;

  task automatic cyc(input logic mr, input logic z, input logic rst,
                     input logic [3:0] st, input logic [17:0] o,
                     input string tag);
    exp_t e;
    memready = mr;
    zero     = z;
    reset    = rst;
    q.push_back('{st: st, o: o});
    @(negedge clk);
    e = q.pop_front();
    checks++;
    assert ({state, outs} === {e.st, e.o}) else begin
      errors++;
      $error("FAIL %s: state=%0d outs=%b, expected state=%0d outs=%b",
             tag, state, outs, e.st, e.o);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    zero = 1'b0;
    memready = 1'b0;
    op = 5'b11000;
    @(posedge clk);
    #1;
    cyc(1, 0, 1, 4'd0, ZZ, "reset");

    // ADDI x2, then SUBI
    for (int i = 0; i < 2; i++) begin
      op = 5'b11000;
      cyc(1, 0, 0, 4'd0, F_R, "addi_fetch");
      cyc(1, 0, 0, 4'd1, DEC, "addi_dec");
      cyc(1, 0, 0, 4'd8, IMA, "addi_exe");
      cyc(1, 0, 0, 4'd9, IWB, "addi_wb");
    end
    op = 5'b11001;
    cyc(1, 0, 0, 4'd0, F_R, "subi_fetch");
    cyc(1, 0, 0, 4'd1, DEC, "subi_dec");
    cyc(1, 0, 0, 4'd8, IMS, "subi_exe");
    cyc(1, 0, 0, 4'd9, IWB, "subi_wb");

    // LW with 3 wait cycles in MEMRD; memready ignored in DECODE
    op = 5'b11010;
    cyc(1, 0, 0, 4'd0, F_R, "lw_fetch");
    cyc(0, 0, 0, 4'd1, DEC, "lw_dec");
    cyc(0, 0, 0, 4'd2, IMA, "lw_adr");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4'd3, MRD, "lw_rd_wait");
    cyc(1, 0, 0, 4'd3, MRD, "lw_rd");
    cyc(0, 0, 0, 4'd4, MWB, "lw_wb");

    // SW with one FETCH wait
    op = 5'b11011;
    cyc(0, 0, 0, 4'd0, F_W, "sw_fetch_wait");
    cyc(1, 0, 0, 4'd0, F_R, "sw_fetch");
    cyc(1, 0, 0, 4'd1, DEC, "sw_dec");
    cyc(1, 0, 0, 4'd2, IMA, "sw_adr");
    cyc(1, 0, 0, 4'd5, MWR, "sw_wr");

    // R-type
    op = 5'b10110;
    cyc(1, 0, 0, 4'd0, F_R, "r_fetch");
    cyc(1, 0, 0, 4'd1, DEC, "r_dec");
    cyc(1, 0, 0, 4'd6, RTE, "r_exe");
    cyc(1, 0, 0, 4'd7, AWB, "r_wb");

    // BEQ zero=1, BNE zero=1, BNE zero=0
    op = 5'b11100;
    cyc(1, 0, 0, 4'd0, F_R, "beq_fetch");
    cyc(1, 0, 0, 4'd1, DEC, "beq_dec");
    cyc(1, 1, 0, 4'd10, BRT, "beq_taken");
    op = 5'b11101;
    cyc(1, 0, 0, 4'd0, F_R, "bne_fetch");
    cyc(1, 0, 0, 4'd1, DEC, "bne_dec");
    cyc(1, 1, 0, 4'd10, BRN, "bne_not_taken");
    cyc(1, 0, 0, 4'd0, F_R, "bne2_fetch");
    cyc(1, 0, 0, 4'd1, DEC, "bne2_dec");
    cyc(1, 0, 0, 4'd10, BRT, "bne_taken");

    // JAL then J
    op = 5'b00111;
    cyc(1, 0, 0, 4'd0, F_R, "jal_fetch");
    cyc(1, 0, 0, 4'd1, DEC, "jal_dec");
    cyc(1, 0, 0, 4'd11, JAL, "jal_jump");
    op = 5'b00000;
    cyc(1, 0, 0, 4'd0, F_R, "j_fetch");
    cyc(1, 0, 0, 4'd1, DEC, "j_dec");
    cyc(1, 0, 0, 4'd11, JMP, "j_jump");

    // Illegal opcode traps and sticks
    op = 5'b11110;
    cyc(1, 0, 0, 4'd0, F_R, "ill_fetch");
    cyc(1, 0, 0, 4'd1, DEC, "ill_dec");
    for (int i = 0; i < 20; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
          4'd12, TIL, "ill_trap");
    cyc(1, 0, 1, 4'd12, ZZ, "ill_reset");
    op = 5'b11000;
    cyc(0, 0, 0, 4'd0, F_W, "ill_after_reset");

    // Timeout: 16 stalled FETCH cycles, then TRAP with buserr
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 4'd0, F_W, "tmo_wait");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4'd12, TBE, "tmo_trap");
    cyc(1, 0, 1, 4'd12, ZZ, "tmo_reset");

    // memready arrives on the limit cycle: normal completion
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 4'd0, F_W, "lim_wait");
    cyc(1, 0, 0, 4'd0, F_R, "lim_ready");
    cyc(1, 0, 0, 4'd1, DEC, "lim_dec");
    cyc(1, 0, 0, 4'd8, IMA, "lim_exe");
    cyc(1, 0, 0, 4'd9, IWB, "lim_wb");

    // Reset during MEMWR aborts the store
    op = 5'b11011;
    cyc(1, 0, 0, 4'd0, F_R, "rsw_fetch");
    cyc(1, 0, 0, 4'd1, DEC, "rsw_dec");
    cyc(1, 0, 0, 4'd2, IMA, "rsw_adr");
    cyc(1, 0, 1, 4'd5, ZZ, "rsw_reset");
    cyc(1, 0, 0, 4'd0, F_R, "rsw_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
